// File: rtl/buyruk_bellek_yukleyici.sv
// Loadable instruction memory for the islemci core.
// A byte-stream loader fills it; the core is held in reset until loading ends.
module buyruk_bellek_yukleyici #(
    parameter int          DERINLIK  = 128,
    parameter logic [31:0] BASLANGIC = 32'h0,
    parameter logic [31:0] NOP       = 32'h00000013
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              yukle_gecerli,
    input  logic [7:0]                        yukle_bayt,
    input  logic                              yukle_son,
    output logic                              yukle_hazir,
    input  logic                              yeniden_yukle,
    input  logic [31:0]                       ps,
    output logic [31:0]                       buyruk,
    output logic                              islemci_rst,
    output logic                              calis,
    output logic [$clog2(DERINLIK+1)-1:0]     yuklenen_sayi,
    output logic                              tasma,
    output logic                              aralik_hata,
    output logic                              hizalama_hata
);

    localparam int SW = $clog2(DERINLIK + 1);
    localparam int AW = $clog2(DERINLIK);
    localparam logic [SW-1:0] DOLU = SW'(DERINLIK);

    typedef enum logic {
        YUKLE,
        CALIS
    } durum_t;

    durum_t durum;
    durum_t durum_sonraki;

    logic [31:0]   mem [DERINLIK];
    logic [SW-1:0] wptr;
    logic [1:0]    bsay;
    logic [31:0]   topla;
    logic [31:0]   kelime;
    logic [31:0]   indeks;
    logic          kabul;
    logic          dolu;
    logic          yaz;
    logic          adres_gecersiz;

    assign kabul  = yukle_gecerli & (durum == YUKLE);
    assign dolu   = (wptr == DOLU);
    // Bytes above the current slot are already zero, so a short last word pads itself.
    assign kelime = topla | ({24'h0, yukle_bayt} << {bsay, 3'b000});
    assign yaz    = ~rst & kabul & ~dolu & ((bsay == 2'd3) | yukle_son);

    // Subtraction may wrap below the base; the explicit ps < BASLANGIC test catches it.
    assign indeks         = (ps - BASLANGIC) >> 2;
    assign adres_gecersiz = (ps < BASLANGIC) | (indeks >= 32'(wptr));

    assign yuklenen_sayi = wptr;
    assign islemci_rst   = rst | ~calis;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= YUKLE;
        end else begin
            durum <= durum_sonraki;
        end
    end

    // Next state and state-only outputs.
    always_comb begin
        durum_sonraki = durum;
        yukle_hazir   = 1'b0;
        calis         = 1'b0;
        unique case (durum)
            YUKLE: begin
                yukle_hazir = 1'b1;
                if (yukle_gecerli && yukle_son) begin
                    durum_sonraki = CALIS;
                end
            end
            CALIS: begin
                calis = 1'b1;
                if (yeniden_yukle) begin
                    durum_sonraki = YUKLE;
                end
            end
            default: durum_sonraki = YUKLE;
        endcase
    end

    // Memory write port; contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (yaz) begin
            mem[wptr[AW-1:0]] <= kelime;
        end
    end

    // Loader assembly, fetch register and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            bsay          <= '0;
            topla         <= '0;
            tasma         <= 1'b0;
            aralik_hata   <= 1'b0;
            hizalama_hata <= 1'b0;
            buyruk        <= NOP;
        end else begin
            unique case (durum)
                YUKLE: begin
                    buyruk <= NOP;
                    if (kabul) begin
                        if (dolu) begin
                            tasma <= 1'b1;
                        end else if ((bsay == 2'd3) || yukle_son) begin
                            wptr  <= wptr + SW'(1);
                            bsay  <= '0;
                            topla <= '0;
                        end else begin
                            topla <= kelime;
                            bsay  <= bsay + 2'd1;
                        end
                    end
                end
                CALIS: begin
                    if (yeniden_yukle) begin
                        wptr          <= '0;
                        bsay          <= '0;
                        topla         <= '0;
                        tasma         <= 1'b0;
                        aralik_hata   <= 1'b0;
                        hizalama_hata <= 1'b0;
                        buyruk        <= NOP;
                    end else if (ps[1:0] != 2'b00) begin
                        buyruk        <= NOP;
                        hizalama_hata <= 1'b1;
                    end else if (adres_gecersiz) begin
                        buyruk      <= NOP;
                        aralik_hata <= 1'b1;
                    end else begin
                        buyruk <= mem[indeks[AW-1:0]];
                    end
                end
                default: buyruk <= NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_buyruk_bellek_yukleyici.sv
// Bench for buyruk_bellek_yukleyici: two instances (deep at base 0,
// 4 words at base 0x100) share stimulus and are checked against a byte-queue model.
module tb_buyruk_bellek_yukleyici;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        yukle_gecerli = 1'b0;
    logic [7:0]  yukle_bayt = 8'h00;
    logic        yukle_son = 1'b0;
    logic        yeniden_yukle = 1'b0;
    logic [31:0] ps = 32'h0;

    logic        hazir_a, hazir_b;
    logic [31:0] buy_a, buy_b;
    logic        irst_a, irst_b;
    logic        calis_a, calis_b;
    logic [7:0]  sayi_a;
    logic [2:0]  sayi_b;
    logic        tas_a, tas_b;
    logic        ara_a, ara_b;
    logic        hiz_a, hiz_b;

    int n_test = 0;
    int n_fail = 0;

    bq_t         yuklu;
    int          e_say [2];
    bit          e_tas [2];
    bit          e_ara [2];
    bit          e_hiz [2];
    logic [31:0] e_buy [2];
    bit          e_calis;

    always #5 clk = ~clk;

    buyruk_bellek_yukleyici u_a (
        .clk(clk), .rst(rst),
        .yukle_gecerli(yukle_gecerli), .yukle_bayt(yukle_bayt),
        .yukle_son(yukle_son), .yukle_hazir(hazir_a),
        .yeniden_yukle(yeniden_yukle), .ps(ps), .buyruk(buy_a),
        .islemci_rst(irst_a), .calis(calis_a), .yuklenen_sayi(sayi_a),
        .tasma(tas_a), .aralik_hata(ara_a), .hizalama_hata(hiz_a)
    );

    buyruk_bellek_yukleyici #(
        .DERINLIK(4), .BASLANGIC(32'h100), .NOP(NOP)
    ) u_b (
        .clk(clk), .rst(rst),
        .yukle_gecerli(yukle_gecerli), .yukle_bayt(yukle_bayt),
        .yukle_son(yukle_son), .yukle_hazir(hazir_b),
        .yeniden_yukle(yeniden_yukle), .ps(ps), .buyruk(buy_b),
        .islemci_rst(irst_b), .calis(calis_b), .yuklenen_sayi(sayi_b),
        .tasma(tas_b), .aralik_hata(ara_b), .hizalama_hata(hiz_b)
    );

    task automatic kontrol(input string tag, input logic [31:0] g,
                           input logic [31:0] e);
        n_test++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, g, e);
        end
    endtask

    function automatic int dep(int m);
        return (m == 0) ? 128 : 4;
    endfunction

    function automatic logic [31:0] bas(int m);
        return (m == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic logic [31:0] kelime_al(int w);
        logic [31:0] r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (4 * w + k < yuklu.size()) r[8*k +: 8] = yuklu[4*w+k];
        end
        return r;
    endfunction

    function automatic void model_giris();
        for (int m = 0; m < 2; m++) begin
            e_say[m] = 0; e_tas[m] = 0; e_ara[m] = 0; e_hiz[m] = 0;
            e_buy[m] = NOP;
        end
        e_calis = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic durum_kontrol();
        kontrol("calis_a", calis_a, e_calis);
        kontrol("irst_a", irst_a, rst | !e_calis);
        kontrol("hazir_a", hazir_a, !e_calis);
        kontrol("sayi_a", sayi_a, e_say[0]);
        kontrol("tasma_a", tas_a, e_tas[0]);
        kontrol("aralik_a", ara_a, e_ara[0]);
        kontrol("hizalama_a", hiz_a, e_hiz[0]);
        kontrol("buyruk_a", buy_a, e_buy[0]);
        kontrol("calis_b", calis_b, e_calis);
        kontrol("irst_b", irst_b, rst | !e_calis);
        kontrol("hazir_b", hazir_b, !e_calis);
        kontrol("sayi_b", sayi_b, e_say[1]);
        kontrol("tasma_b", tas_b, e_tas[1]);
        kontrol("aralik_b", ara_b, e_ara[1]);
        kontrol("hizalama_b", hiz_b, e_hiz[1]);
        kontrol("buyruk_b", buy_b, e_buy[1]);
    endtask

    task automatic sifirla();
        rst = 1'b1;
        tick();
        model_giris();
        durum_kontrol();
        rst = 1'b0;
    endtask

    task automatic yeniden();
        yeniden_yukle = 1'b1;
        tick();
        yeniden_yukle = 1'b0;
        model_giris();
        durum_kontrol();
    endtask

    // Bytes must start at a fresh load; random idle gaps may carry reload pulses.
    task automatic yukle(input bq_t b, input bit son_var);
        int nb = 0;
        for (int i = 0; i < b.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                yukle_gecerli = 1'b0;
                yeniden_yukle = 1'($urandom_range(0, 1));
                yukle_bayt    = 8'($urandom);
                tick();
                yeniden_yukle = 1'b0;
                durum_kontrol();
            end
            yukle_gecerli = 1'b1;
            yukle_bayt    = b[i];
            yukle_son     = son_var && (i == b.size() - 1);
            tick();
            nb++;
            for (int m = 0; m < 2; m++) begin
                int w = yukle_son ? (nb + 3) / 4 : nb / 4;
                e_say[m] = (w > dep(m)) ? dep(m) : w;
                e_tas[m] = nb > 4 * dep(m);
            end
            if (yukle_son) begin
                e_calis = 1;
                yuklu = b;
            end
            durum_kontrol();
        end
        yukle_gecerli = 1'b0;
        yukle_son     = 1'b0;
    endtask

    task automatic getir(input logic [31:0] p);
        ps            = p;
        yukle_gecerli = 1'($urandom);
        yukle_bayt    = 8'($urandom);
        yukle_son     = 1'($urandom);
        tick();
        yukle_gecerli = 1'b0;
        yukle_son     = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (p[1:0] != 2'b00) begin
                e_buy[m] = NOP;
                e_hiz[m] = 1;
            end else if (p < bas(m) || ((p - bas(m)) >> 2) >= e_say[m]) begin
                e_buy[m] = NOP;
                e_ara[m] = 1;
            end else begin
                e_buy[m] = kelime_al(int'((p - bas(m)) >> 2));
            end
        end
        durum_kontrol();
    endtask

    function automatic logic [31:0] rastgele_ps();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 71)) * 4;
            1: return 32'h100 + 32'($urandom_range(0, 7)) * 4;
            2: return $urandom;
            default: return 32'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        bq_t b;
        model_giris();
        sifirla();
        tick();
        durum_kontrol();

        b = '{8'h13, 8'h03, 8'h43, 8'h01, 8'h93, 8'h82, 8'h62, 8'hFF,
              8'hB3, 8'h83, 8'h62, 8'h00};
        yukle(b, 1);
        kontrol("normal_sayi", sayi_a, 32'd3);
        getir(32'h0);
        kontrol("normal_w0", buy_a, 32'h01430313);
        getir(32'h4);
        kontrol("normal_w1", buy_a, 32'hFF628293);
        getir(32'h8);
        kontrol("normal_w2", buy_a, 32'h006283B3);
        getir(32'hC);
        kontrol("yuksuz_aralik", ara_a, 32'd1);
        getir(32'h1000);
        getir(32'h2);
        kontrol("hizalama", hiz_a, 32'd1);
        getir(32'h104);

        yeniden();
        b = '{8'h93, 8'h80, 8'h50, 8'h00};
        yukle(b, 1);
        getir(32'h0);
        kontrol("yeniden_w0", buy_a, 32'h00508093);
        getir(32'h100);

        yeniden();
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        yukle(b, 1);
        kontrol("kismi_sayi", sayi_a, 32'd2);
        getir(32'h4);
        kontrol("kismi_w1", buy_a, 32'h00006655);

        yeniden();
        b = {};
        for (int i = 0; i < 20; i++) b.push_back(8'(i * 7 + 1));
        yukle(b, 1);
        kontrol("tasma_b", tas_b, 32'd1);
        kontrol("tasma_sayi_b", sayi_b, 32'd4);
        for (int w = 0; w < 5; w++) begin
            getir(32'h100 + 32'(w) * 4);
            getir(32'(w) * 4);
        end

        yeniden();
        b = '{8'h5A, 8'hA5};
        yukle(b, 0);
        sifirla();
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        yukle(b, 1);
        getir(32'h0);
        kontrol("ara_reset_w0", buy_a, 32'hDDCCBBAA);
        getir(32'h100);
        getir(32'h4);

        for (int it = 0; it < 4; it++) begin
            yeniden();
            b = {};
            for (int i = 0; i < $urandom_range(1, 24); i++) b.push_back(8'($urandom));
            yukle(b, 1);
            repeat (12) getir(rastgele_ps());
        end

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
